// File: rtl/serial_frame_tx.sv
// serial_frame_tx: packs a parallel request (port, length, data) into a serial
// frame for the port-demux receiver. Line idles high; a frame is a 0 start bit,
// the port field MSB first, the length field MSB first, L payload bits LSB
// first, then MIN_IDLE high bits. Bits advance only on clkEn-qualified edges;
// requests are accepted on any clk edge while idle.
module serial_frame_tx #(
  parameter int PORT_W   = 2,
  parameter int LEN_W    = 4,
  parameter int DATA_W   = 16,
  parameter int MIN_IDLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PORT_W-1:0] in_port,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done,
  output logic              len_err
);

  // bit_cnt must hold PORT_W-1, LEN_W-1 and the largest L-1 (2^LEN_W-2)
  localparam int PCNT_W = (PORT_W > 1) ? $clog2(PORT_W) : 1;
  localparam int CNT_W  = (PCNT_W > LEN_W) ? PCNT_W : LEN_W;
  localparam int GAP_W  = (MIN_IDLE > 1) ? $clog2(MIN_IDLE) : 1;

  if (DATA_W < (1 << LEN_W) - 1) begin : g_data_w_check
    $error("serial_frame_tx: DATA_W must be at least 2**LEN_W-1");
  end
  if (MIN_IDLE < 1) begin : g_min_idle_check
    $error("serial_frame_tx: MIN_IDLE must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PORT  = 3'd2,
    LEN   = 3'd3,
    DATA  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  // Field holding registers; fields go out MSB first (port, len) or LSB first (data)
  logic [PORT_W-1:0]  port_sh;
  logic [LEN_W-1:0]   len_sh;
  logic [LEN_W-1:0]   len_val;
  logic [DATA_W-1:0]  data_sh;

  // Shifted views, so the next bit to drive is always a fixed bit position
  logic [PORT_W-1:0]  port_nx;
  logic [LEN_W-1:0]   len_nx;
  logic [DATA_W-1:0]  data_nx;

  logic               accept;

  // Ready only while idle and not being reset; purely a function of state and rst
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Next-bit views of the field shift registers
  always_comb begin
    port_nx = port_sh << 1;
    len_nx  = len_sh << 1;
    data_nx = data_sh >> 1;
  end

  // Field registers: load on accept, shift on clkEn edges in the matching state
  always_ff @(posedge clk) begin
    if (accept) begin
      port_sh <= in_port;
      len_sh  <= in_len;
      len_val <= in_len;
      data_sh <= in_data;
    end else if (clkEn) begin
      case (state)
        PORT:    port_sh <= port_nx;
        LEN:     len_sh  <= len_nx;
        DATA:    data_sh <= data_nx;
        default: ;
      endcase
    end
  end

  // Frame FSM; ser_out is loaded with the bit belonging to the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ser_out    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      case (state)
        IDLE: begin
          ser_out <= 1'b1;
          if (accept) begin
            if (in_len == '0) begin
              // Empty payload: drop the request and flag it, line stays high
              len_err <= 1'b1;
            end else begin
              // Start bit appears from the next clk and holds until a clkEn edge
              state   <= START;
              ser_out <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end

        START: begin
          if (clkEn) begin
            state   <= PORT;
            bit_cnt <= CNT_W'(PORT_W - 1);
            ser_out <= port_sh[PORT_W-1];
          end
        end

        PORT: begin
          if (clkEn) begin
            if (bit_cnt == '0) begin
              state   <= LEN;
              bit_cnt <= CNT_W'(LEN_W - 1);
              ser_out <= len_sh[LEN_W-1];
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
              ser_out <= port_nx[PORT_W-1];
            end
          end
        end

        LEN: begin
          if (clkEn) begin
            if (bit_cnt == '0) begin
              state   <= DATA;
              bit_cnt <= CNT_W'(len_val) - CNT_W'(1);
              ser_out <= data_sh[0];
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
              ser_out <= len_nx[LEN_W-1];
            end
          end
        end

        DATA: begin
          if (clkEn) begin
            if (bit_cnt == '0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(MIN_IDLE - 1);
              ser_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - CNT_W'(1);
              ser_out <= data_nx[0];
            end
          end
        end

        GAP: begin
          ser_out <= 1'b1;
          if (clkEn) begin
            if (gap_cnt == '0) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
        end

        default: begin
          state   <= IDLE;
          ser_out <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed frame vectors with hand-computed bit
// streams plus sequences for reset, empty payload and back-to-back frames.
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_port;
  logic [3:0]  in_len;
  logic [15:0] in_data;
  logic        ser_out;
  logic        busy;
  logic        frame_done;
  logic        len_err;

  always #5 clk = ~clk;

  serial_frame_tx #(
    .PORT_W  (2),
    .LEN_W   (4),
    .DATA_W  (16),
    .MIN_IDLE(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_port   (in_port),
    .in_len    (in_len),
    .in_data   (in_data),
    .ser_out   (ser_out),
    .busy      (busy),
    .frame_done(frame_done),
    .len_err   (len_err)
  );

  typedef struct {
    logic [1:0]  port;
    logic [3:0]  len;
    logic [15:0] data;
    int          div;
    int          nbits;
    logic [31:0] bits;   // expected line bits, first bit at position nbits-1
  } vec_t;

  vec_t vecs[3];

  int errors = 0;
  int checks = 0;
  int en_div = 4;
  int en_ph  = 0;
  int done_cnt = 0;
  int ready_in_frame = 0;
  bit cap_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clk: record the bit the receiver would sample at a clkEn edge, then advance
  task automatic step();
    if (clk_en && busy) cap_q.push_back(ser_out);
    @(posedge clk);
    #1;
    en_ph  = (en_ph + 1) % en_div;
    clk_en = (en_ph == 0);
    if (frame_done) done_cnt++;
    if (busy && in_ready) ready_in_frame++;
  endtask

  task automatic set_div(input int d);
    en_div = d;
    en_ph  = 0;
    clk_en = 1'b1;
  endtask

  function automatic logic [31:0] packed_cap();
    logic [31:0] g = '0;
    foreach (cap_q[i]) g = {g[30:0], cap_q[i]};
    return g;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Start, port 00, len 0010, data bits 0,1, gap
    vecs[0] = '{2'b00, 4'd2, 16'h0002, 4, 10, 32'b0000010011};
    // Start, port 10, len 0011, data 1,0,1, gap
    vecs[1] = '{2'b10, 4'd3, 16'h0005, 4, 11, 32'b01000111011};
    // clkEn every clk: start, port 11, len 0100, data 0,1,0,1, gap
    vecs[2] = '{2'b11, 4'd4, 16'h000A, 1, 12, 32'b011010001011};

    rst = 1'b1; clk_en = 1'b0; in_valid = 1'b0;
    in_port = '0; in_len = '0; in_data = '0;
    repeat (3) step();
    check("rst_ser_out", ser_out, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_len_err", len_err, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Quiet line for 20 bit periods
    begin
      int bad = 0;
      set_div(4);
      repeat (80) begin
        step();
        if (ser_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      check("idle_stable", bad, 0);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_idle_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    step();

    // Empty payload is dropped with a one-clk error pulse
    done_cnt = 0;
    in_valid = 1'b1; in_port = 2'b11; in_len = 4'd0; in_data = 16'hFFFF;
    step();
    in_valid = 1'b0;
    check("len0_err_pulse", len_err, 1);
    check("len0_busy", busy, 0);
    check("len0_ser_out", ser_out, 1);
    check("len0_in_ready", in_ready, 1);
    step();
    check("len0_err_clear", len_err, 0);
    repeat (40) step();
    check("len0_no_done", done_cnt, 0);
    check("len0_line_high", ser_out, 1);

    // Reset while the payload of an L=8 frame is going out
    set_div(4);
    cap_q.delete();
    done_cnt = 0;
    in_valid = 1'b1; in_port = 2'b01; in_len = 4'd8; in_data = 16'h00A5;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 200 && cap_q.size() < 9; k++) step();
    check("rst_data_reached", cap_q.size(), 9);
    rst = 1'b1;
    step();
    check("rst_data_ser_out", ser_out, 1);
    check("rst_data_busy", busy, 0);
    check("rst_data_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_data_ready_back", in_ready, 1);
    repeat (40) step();
    check("rst_data_no_done", done_cnt, 0);

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      logic [1:0]  dport;
      logic [3:0]  dlen;
      logic [15:0] ddata;
      logic [31:0] mask;
      set_div(vecs[v].div);
      cap_q.delete();
      done_cnt = 0;
      ready_in_frame = 0;
      in_valid = 1'b1;
      in_port = vecs[v].port; in_len = vecs[v].len; in_data = vecs[v].data;
      step();
      // Inputs change after the accept edge and must not leak into the frame
      in_valid = 1'b0;
      in_port = ~vecs[v].port; in_len = ~vecs[v].len; in_data = ~vecs[v].data;
      check($sformatf("v%0d_busy", v), busy, 1);
      check($sformatf("v%0d_ready_low", v), in_ready, 0);
      for (int k = 0; k < 400 && done_cnt == 0; k++) step();
      check($sformatf("v%0d_done_seen", v), done_cnt, 1);
      check($sformatf("v%0d_nbits", v), cap_q.size(), vecs[v].nbits);
      mask = (32'd1 << vecs[v].nbits) - 32'd1;
      check($sformatf("v%0d_bits", v), packed_cap() & mask, vecs[v].bits);
      check($sformatf("v%0d_ready_in_frame", v), ready_in_frame, 0);
      // Receiver-side decode of the captured stream
      dport = '0; dlen = '0; ddata = '0;
      if (cap_q.size() >= 7) begin
        for (int i = 1; i <= 2; i++) dport = {dport[0], cap_q[i]};
        for (int i = 3; i <= 6; i++) dlen = {dlen[2:0], cap_q[i]};
        for (int i = 0; i < int'(dlen) && (7 + i) < cap_q.size(); i++)
          ddata[i[3:0]] = cap_q[7 + i];
      end
      check($sformatf("v%0d_rx_port", v), dport, vecs[v].port);
      check($sformatf("v%0d_rx_len", v), dlen, vecs[v].len);
      check($sformatf("v%0d_rx_data", v), ddata, vecs[v].data);
      repeat (8) step();
      check($sformatf("v%0d_single_done", v), done_cnt, 1);
      check($sformatf("v%0d_after_line", v), ser_out, 1);
      check($sformatf("v%0d_after_ready", v), in_ready, 1);
    end

    // Back-to-back requests with in_valid held high
    set_div(4);
    cap_q.delete();
    done_cnt = 0;
    in_valid = 1'b1; in_port = 2'b01; in_len = 4'd1; in_data = 16'h0001;
    step();
    in_port = 2'b11; in_len = 4'd15; in_data = 16'h7FFF;
    for (int k = 0; k < 300 && done_cnt == 0; k++) step();
    check("b2b_first_done", done_cnt, 1);
    check("b2b_ready_at_done", in_ready, 1);
    step();
    check("b2b_second_accepted", busy, 1);
    in_valid = 1'b0;
    for (int k = 0; k < 400 && done_cnt < 2; k++) step();
    check("b2b_second_done", done_cnt, 2);
    // Frame 1: 0,01,0001,1,gap 1 (9 bits); frame 2: start 0 then 22 ones incl. gap
    check("b2b_total_bits", cap_q.size(), 32);
    check("b2b_bits", packed_cap(), {9'b001000111, 1'b0, 22'h3FFFFF});
    if (cap_q.size() >= 10) begin
      check("b2b_gap_high", cap_q[8], 1);
      check("b2b_next_start", cap_q[9], 0);
    end else begin
      check("b2b_gap_present", cap_q.size(), 32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
